scan_scheduler: RTL
===================

# scan_scheduler

Ping-pong scheduler for two `scanner` instances that share one 8-bit transfer channel. Runs a job of `JOB_LEN` scans and alternates scanners so that one scanner scans while the other transfers. It issues single-cycle `start_scan`, `transfer` and `flush` commands, drives the output mux select, and recovers from a stalled scanner via a watchdog. It sits between host control logic and the two scanners.

## Interface
- `JOB_LEN`, default 4: scans per job; legal range 1–255.
- `TIMEOUT`, default 64: maximum cycles spent waiting for any single scanner state change before the job aborts; legal range 2–65535.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `go`  in  1  start-job pulse; ignored unless the block is in `IDLE`.
- `abort`  in  1  host abort request; a level, sampled every cycle.
- `sc_state0`, `sc_state1`  in  3 each  scanner state codes: 0 lowPower, 1 active, 2 standby, 3 idle, 4 flush, 5 transtage.
- `sc_next0`, `sc_next1`  in  1 each  scanner `start_second_buffer` outputs.
- `start_scan`  out  2  one-hot start pulse; bit i drives scanner i.
- `transfer`  out  2  one-hot transfer pulse.
- `flush`  out  2  flush pulse.
- `xfer_sel`  out  1  selects which scanner's `data_out` reaches the channel.
- `busy`  out  1  high whenever the block is not in `IDLE`.
- `done`  out  1  one-cycle pulse when a job ends.
- `error`  out  1  sticky flag: the last job aborted; cleared by the next `go`.
- `remaining`  out  8  scans not yet transferred.

## Operation
- All outputs are registered. Reset values: every output is 0, the FSM is in `IDLE`, and `cur` = 0.
- Scanner state "free" means code 0 or 2.
- FSM states: `IDLE`, `SCAN`, `XFER`, `FLUSH`, `DONE`.
- `IDLE`: on `go`:
  - load `remaining` = `JOB_LEN`, set `cur` = 0, clear `error`;
  - pulse `start_scan[0]`;
  - go to `SCAN`.
- `SCAN` (scanner `cur` active):
  - Prestart: if `sc_next[cur]`=1, `remaining` ≥ 2, `other_started`=0 and scanner `!cur` is free, pulse `start_scan[!cur]` once and set `other_started`.
  - When `sc_state[cur]` = 3: pulse `transfer[cur]`, set `xfer_sel` = `cur`, go to `XFER`.
- `XFER`: wait for `sc_state[cur]` = 0, then decrement `remaining`.
  - If the result is 0: go to `DONE`.
  - Otherwise: set `cur` = `!cur`. If `other_started`=0, pulse `start_scan[cur]` now. Clear `other_started`. Go to `SCAN`.
- `xfer_sel` changes only on entry to `XFER`; it holds through the following `SCAN`.
- `DONE`: pulse `done`, go to `IDLE`.
- `abort`, or watchdog expiry in `SCAN`/`XFER`, sends the FSM to `FLUSH` and sets `error`.
- `FLUSH`:
  - Pulse `flush[i]` once for each scanner whose code is 3.
  - Stay until both scanners are free or `TIMEOUT` cycles elapse, then go to `DONE`.
  - `remaining` is frozen.
- Watchdog: a 16-bit counter that clears on every FSM state change and on any change of `sc_state[cur]`. Expiry is counter = `TIMEOUT`−1.
- Priority within one cycle: `abort` > watchdog > normal transitions. A `go` arriving while `busy` is dropped.
- If `rst` is asserted mid-job, all state is cleared immediately and no pulses are emitted; the scanners are reset independently.

## Timing
- `go` → `start_scan[0]`: 1 cycle.
- `sc_state[cur]`=3 seen → `transfer[cur]`: 1 cycle.
- `sc_state[cur]`=0 seen in `XFER` → next `start_scan` (if not prestarted): 1 cycle, in the same cycle as the `remaining` decrement.
- Final transfer completion → `done`: 2 cycles (`XFER`→`DONE`, then the pulse).
- Command pulses are exactly 1 cycle wide. At most one bit of each command vector is high in any cycle.
- `JOB_LEN`=1: prestart never fires; the job ends after the first transfer.

## Test plan
- **Normal job:** `JOB_LEN`=4, behavioural scanners, `go` pulse → `start_scan` sequence 01, 10, 01, 10; `xfer_sel` toggles 0,1,0,1; `remaining` steps 4→0; one `done`; `error`=0.
- **Prestart:** `sc_next0` rises during scan 1 while scanner 1 is in standby → `start_scan`=10 in the next cycle, only once; no second `start_scan[1]` after `XFER`.
- **Single-scan job:** `JOB_LEN`=1 → exactly one `start_scan[0]` and one `transfer[0]`; `done` asserts 2 cycles after scanner 0 returns to state 0.
- **Abort during idle:** `abort` while scanner 0 is in state 3 → `flush`=01 for one cycle; `error`=1; `done` after both scanners are free; `remaining` unchanged.
- **Watchdog:** scanner 1 held in state 1, `TIMEOUT`=8 → `FLUSH` entered 8 cycles after the last state change; `error`=1; `done` after flush.
- **Reset and ignored `go`:** `rst` low mid-`XFER` → all outputs 0 the same cycle; a `go` while `busy` is ignored (no extra `start_scan`, `remaining` not reloaded).

Source files
------------

// File: rtl/scan_scheduler.sv
// rtl/scan_scheduler.sv - ping-pong scan/transfer scheduler for two scanners sharing one channel
module scan_scheduler #(
    parameter int JOB_LEN = 4,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       abort,
    input  logic [2:0] sc_state0,
    input  logic [2:0] sc_state1,
    input  logic       sc_next0,
    input  logic       sc_next1,
    output logic [1:0] start_scan,
    output logic [1:0] transfer,
    output logic [1:0] flush,
    output logic       xfer_sel,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] remaining
);
    typedef enum logic [2:0] {IDLE, SCAN, XFER, FLUSH, DONE} state_t;

    localparam logic [2:0]  SC_LOW     = 3'd0;
    localparam logic [2:0]  SC_STANDBY = 3'd2;
    localparam logic [2:0]  SC_IDLE    = 3'd3;
    localparam logic [15:0] WD_LAST    = 16'(TIMEOUT - 1);
    localparam logic [7:0]  JOB_LEN_W  = 8'(JOB_LEN);

    state_t      state, state_nx;
    logic        cur, cur_nx;
    logic        other_started, other_started_nx;
    logic [1:0]  flushed, flushed_nx;
    logic [15:0] wd, wd_nx;
    logic [2:0]  sc_prev;

    logic [1:0]  start_d, transfer_d, flush_d;
    logic        xfer_sel_d, done_d, error_d;
    logic [7:0]  remaining_d;

    logic [2:0]  sc_cur, sc_oth, sc_cur_nx;
    logic        next_cur, oth_free, both_free, wd_exp, kill, prestart, last_scan, wd_clear;
    logic [1:0]  flush_pick;

    assign sc_cur     = cur ? sc_state1 : sc_state0;
    assign sc_oth     = cur ? sc_state0 : sc_state1;
    assign sc_cur_nx  = cur_nx ? sc_state1 : sc_state0;
    assign next_cur   = cur ? sc_next1 : sc_next0;
    assign oth_free   = (sc_oth == SC_LOW) || (sc_oth == SC_STANDBY);
    assign both_free  = ((sc_state0 == SC_LOW) || (sc_state0 == SC_STANDBY)) &&
                        ((sc_state1 == SC_LOW) || (sc_state1 == SC_STANDBY));
    assign wd_exp     = (wd == WD_LAST);
    assign kill       = ((state == SCAN) || (state == XFER)) && (abort || wd_exp);
    assign prestart   = (state == SCAN) && next_cur && (remaining >= 8'd2) &&
                        !other_started && oth_free;
    assign last_scan  = (remaining == 8'd1);
    // One flush per cycle keeps the command vector one-hot when both scanners hold data.
    assign flush_pick = ((sc_state0 == SC_IDLE) && !flushed[0]) ? 2'b01 :
                        ((sc_state1 == SC_IDLE) && !flushed[1]) ? 2'b10 : 2'b00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cur           <= 1'b0;
            other_started <= 1'b0;
            flushed       <= 2'b00;
            wd            <= 16'd0;
            sc_prev       <= 3'd0;
            start_scan    <= 2'b00;
            transfer      <= 2'b00;
            flush         <= 2'b00;
            xfer_sel      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            remaining     <= 8'd0;
        end else begin
            state         <= state_nx;
            cur           <= cur_nx;
            other_started <= other_started_nx;
            flushed       <= flushed_nx;
            wd            <= wd_nx;
            sc_prev       <= sc_cur_nx;
            start_scan    <= start_d;
            transfer      <= transfer_d;
            flush         <= flush_d;
            xfer_sel      <= xfer_sel_d;
            busy          <= (state_nx != IDLE);
            done          <= done_d;
            error         <= error_d;
            remaining     <= remaining_d;
        end
    end

    always_comb begin
        state_nx         = state;
        cur_nx           = cur;
        other_started_nx = other_started;
        flushed_nx       = flushed;
        if (kill) begin
            state_nx   = FLUSH;
            flushed_nx = 2'b00;
        end else begin
            case (state)
                IDLE: if (go) begin
                    state_nx         = SCAN;
                    cur_nx           = 1'b0;
                    other_started_nx = 1'b0;
                end
                SCAN: begin
                    if (prestart) other_started_nx = 1'b1;
                    if (sc_cur == SC_IDLE) state_nx = XFER;
                end
                XFER: if (sc_cur == SC_LOW) begin
                    if (last_scan) begin
                        state_nx = DONE;
                    end else begin
                        state_nx         = SCAN;
                        cur_nx           = ~cur;
                        other_started_nx = 1'b0;
                    end
                end
                FLUSH: begin
                    flushed_nx = flushed | flush_pick;
                    if (both_free || wd_exp) state_nx = DONE;
                end
                DONE:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
        // In FLUSH the counter measures plain elapsed time, so scanner activity must not restart it.
        wd_clear = (state_nx != state) || ((state != FLUSH) && (sc_cur != sc_prev));
        if (wd_clear)              wd_nx = 16'd0;
        else if (wd == 16'hFFFF)   wd_nx = wd;
        else                       wd_nx = wd + 16'd1;
    end

    always_comb begin
        start_d     = 2'b00;
        transfer_d  = 2'b00;
        flush_d     = 2'b00;
        done_d      = 1'b0;
        xfer_sel_d  = xfer_sel;
        error_d     = error;
        remaining_d = remaining;
        if (kill) begin
            error_d = 1'b1;
        end else begin
            case (state)
                IDLE: if (go) begin
                    start_d     = 2'b01;
                    remaining_d = JOB_LEN_W;
                    error_d     = 1'b0;
                end
                SCAN: begin
                    if (prestart) start_d = cur ? 2'b01 : 2'b10;
                    if (sc_cur == SC_IDLE) begin
                        transfer_d = cur ? 2'b10 : 2'b01;
                        xfer_sel_d = cur;
                    end
                end
                XFER: if (sc_cur == SC_LOW) begin
                    remaining_d = remaining - 8'd1;
                    if (!last_scan && !other_started) start_d = cur ? 2'b01 : 2'b10;
                end
                FLUSH:   flush_d = flush_pick;
                DONE:    done_d  = 1'b1;
                default: ;
            endcase
        end
    end
endmodule
